// File: rtl/decoder_pkg.sv
// Shared widths, types and constants for the registered 3-to-8 decoder.
package decoder_pkg;

  localparam int SEL_W = 3;
  localparam int OUT_W = 8;

  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [OUT_W-1:0] onehot_t;

  localparam onehot_t ONEHOT_NONE = '0;

endpackage : decoder_pkg

// File: rtl/decoder3to8_core.sv
// Purely combinational enable-gated binary-to-one-hot decode.
module decoder3to8_core
  import decoder_pkg::*;
(
  input  logic             en,
  input  logic [SEL_W-1:0] in,
  output logic [OUT_W-1:0] dec
);

  // Decode the select into a single set bit, or nothing when disabled.
  always_comb begin
    // NOTE: assign a default first so every path drives dec and no latch is inferred.
    dec = ONEHOT_NONE;
    if (en) begin
      dec = onehot_t'(1) << in;
    end
  end

endmodule : decoder3to8_core

// File: rtl/decoder_3to8.sv
// Registered 3-to-8 one-hot decoder with active-high enable.
// Optional build macro DECODER3TO8_IN_REG_EN adds an input register stage
// (latency 2 instead of 1); ports and reset values are the same either way.
module decoder_3to8
  import decoder_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [SEL_W-1:0] in,
  output logic [OUT_W-1:0] out
);

  logic    en_d;
  sel_t    in_d;
  onehot_t dec;

`ifdef DECODER3TO8_IN_REG_EN
  logic en_q;
  sel_t in_q;

  // Capture select and enable one cycle ahead of the decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q <= 1'b0;
      in_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      en_q <= en;
      in_q <= in;
    end
  end

  assign en_d = en_q;
  assign in_d = in_q;
`else
  assign en_d = en;
  assign in_d = in;
`endif

  decoder3to8_core u_core (
    .en  (en_d),
    .in  (in_d),
    .dec (dec)
  );

  // Output register: glitch-free one-hot, cleared asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= ONEHOT_NONE;
    end else begin
      out <= dec;
    end
  end

`ifndef SYNTHESIS
  logic en_out;

  // Track the enable that produced the value currently held in out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_out <= 1'b0;
    end else begin
      en_out <= en_d;
    end
  end

  a_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(out))
    else $error("decoder_3to8: out has more than one bit set");

  a_onehot_en : assert property (@(posedge clk) disable iff (!rst_n) en_out |-> $onehot(out))
    else $error("decoder_3to8: out not one-hot while enabled");
`endif

endmodule : decoder_3to8

// File: tb/tb_decoder_3to8.sv
// Directed self-checking bench for decoder_3to8 (either build variant).
module tb_decoder_3to8;

`ifdef DECODER3TO8_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [2:0] in;
  logic [7:0] out;

  int total = 0;
  int bad   = 0;

  // Expected outputs, one per clock edge since the last reset release.
  logic [7:0] hist[$];

  decoder_3to8 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .in    (in),
    .out   (out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%02h expected=%02h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply inputs, clock once, and compare against the value expected LAT edges ago.
  task automatic drive(input string tag, input logic e, input logic [2:0] s, input logic [7:0] exp);
    logic [7:0] want;
    en = e;
    in = s;
    @(posedge clk);
    #1;
    hist.push_back(exp);
    want = (hist.size() >= LAT) ? hist[hist.size() - LAT] : 8'h00;
    check(tag, out, want);
  endtask

  logic [7:0] sweep_exp [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

  initial begin
    rst_n = 1'b1;
    en    = 1'b1;
    in    = 3'b101;

    // Asynchronous reset before any clock edge, inputs active.
    #2 rst_n = 1'b0;
    #1 check("rst_async", out, 8'h00);
    @(posedge clk); #1 check("rst_hold0", out, 8'h00);
    @(posedge clk); #1 check("rst_hold1", out, 8'h00);
    #3 rst_n = 1'b1;
    hist.delete();
    for (int i = 0; i < LAT; i++) drive("rst_release", 1'b1, 3'b101, 8'h20);

    // Disabled.
    for (int i = 0; i < LAT + 1; i++) drive("disabled", 1'b0, 3'b000, 8'h00);

    // Full sweep on consecutive cycles, then flush the pipeline.
    for (int i = 0; i < 8; i++) drive($sformatf("sweep%0d", i), 1'b1, 3'(i), sweep_exp[i]);
    for (int i = 1; i < LAT; i++) drive("sweep_flush", 1'b1, 3'd7, 8'h80);

    // Enable toggle with in held at 3.
    drive("en_hi", 1'b1, 3'b011, 8'h08);
    drive("en_lo", 1'b0, 3'b011, 8'h00);
    drive("en_hi2", 1'b1, 3'b011, 8'h08);
    for (int i = 1; i < LAT; i++) drive("en_flush", 1'b1, 3'b011, 8'h08);

    // Async reset mid-operation while out shows 8'h10.
    for (int i = 0; i < LAT; i++) drive("pre_rst", 1'b1, 3'b100, 8'h10);
    #2 rst_n = 1'b0;
    #1 check("mid_rst_async", out, 8'h00);
    @(posedge clk); #1 check("mid_rst_hold", out, 8'h00);
    #3 rst_n = 1'b1;
    hist.delete();
    for (int i = 0; i < LAT; i++) drive("post_rst", 1'b1, 3'b100, 8'h10);
    drive("post_rst_next", 1'b1, 3'b110, 8'h40);
    for (int i = 1; i < LAT; i++) drive("post_rst_flush", 1'b1, 3'b110, 8'h40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_decoder_3to8
